sha256_msg_schedule: RTL
========================

// Module: sha256_msg_schedule
// PURPOSE
//  SHA-256 message-schedule producer: accepts one 512-bit block as 16 x 32-bit words, then streams W[0..ROUNDS-1] to the round/compression datapath that consumes the Ch/Maj/Sigma functions.
//  Words W[16..] are expanded on the fly in a 16-entry circular buffer, so there is no 64-word store.
//  Sits between the padding/block loader and the compression core.
// PARAMETERS
//  ROUNDS   64   number of W words emitted per block; legal range 16..64
// PORTS
//  clk        in   1   single clock; all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   block-word valid
//  in_ready   out  1   block-word ready; asserted in LOAD only
//  in_word    in   32  message word, big-endian word order (W0 first)
//  out_valid  out  1   schedule word valid; asserted in EMIT only
//  out_ready  in   1   compression core accepts W
//  out_word   out  32  W[t]
//  out_last   out  1   high with out_valid when t == ROUNDS-1
//  busy       out  1   high whenever state != LOAD or a load is in progress (cnt != 0)
// BEHAVIOUR
//  - Reset: state=LOAD, cnt=0, buf[0..15]=0. Outputs at reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_word=0.
//  - Handshakes: a transfer occurs when valid && ready on a rising edge.
//  - FSM LOAD:
//    - in_ready=1, out_valid=0.
//    - Each in handshake writes buf[cnt[3:0]] <= in_word and increments cnt.
//    - On the 16th handshake (cnt==15): cnt <= 0, state -> EMIT.
//  - FSM EMIT:
//    - in_ready=0, out_valid=1, t = cnt (0..ROUNDS-1).
//    - t<16: out_word = buf[t].
//    - t>=16: out_word = s1(buf[(t-2)%16]) + buf[(t-7)%16] + s0(buf[(t-15)%16]) + buf[(t-16)%16], summed mod 2^32.
//      - This value is combinational from buf.
//      - On the out handshake it is written to buf[t%16].
//    - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
//    - Out handshake increments cnt. On the handshake with t==ROUNDS-1: cnt <= 0, state -> LOAD.
//  - Latency: out_valid rises the cycle after the 16th in handshake. With out_ready held high, one W per cycle.
//  - Back-to-back blocks: in_ready returns 1 the cycle after the last out handshake. No word is emitted twice and none is skipped.
//  - Backpressure: while out_valid && !out_ready, out_word, out_last, buf and cnt hold stable.
//  - in_valid during EMIT is ignored (no write). out_ready during LOAD is ignored.
//  - Reset asserted mid-load or mid-emit: immediate return to reset state.
//    - The partial block is discarded; out_valid drops asynchronously.
//  - out_word when out_valid=0: equals buf[cnt] mux output. Consumers must not sample it.
// CONFIGURATION
//  - SHA256_SCHED_ROUND_IDX_EN defined:
//    - Adds port out_round (out, 6 bits) = t, valid with out_valid; reset value 0.
//    - The compression core uses it to index K[t] and drop its own round counter.
//  - Undefined: port absent; behaviour otherwise identical.
// TESTING
//  - "abc" block: in W0=0x61626380, W1..W14=0, W15=0x00000018, out_ready=1 -> out W0..W15 echo inputs, W16=0x61626380, W17=0x000F0000; 64 words, out_last only on 64th.
//  - All-zero block -> 64 outputs all 0x00000000; state returns to LOAD (in_ready=1) the cycle after 64th handshake.
//  - "abc" with out_ready toggled 1,0,0,1 pseudo-randomly -> identical W sequence to the no-stall run; out_word stable while stalled.
//  - Two blocks back-to-back ("abc" then all-zero), in_valid held high -> in_ready=0 throughout EMIT; second stream all zero; no stray writes.
//  - rst_n low after 9th in word, then full "abc" load -> outputs match the clean "abc" run; also rst_n low at t=30 of EMIT -> out_valid=0 immediately, in_ready=1.
//  - ROUNDS=16 build -> 16 echoed words, out_last at t=15, no expansion; with SHA256_SCHED_ROUND_IDX_EN, out_round counts 0..15 (0..63 default).

Source files
------------

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 block words, then streams W[0..ROUNDS-1] using a 16-entry circular buffer.
// Optional macro SHA256_SCHED_ROUND_IDX_EN adds the out_round port carrying the current round index t.
module sha256_msg_schedule #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
`ifdef SHA256_SCHED_ROUND_IDX_EN
  output logic        busy,
  output logic [5:0]  out_round
`else
  output logic        busy
`endif
);

  typedef enum logic {LOAD, EMIT} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [31:0] wbuf [16];
  logic [3:0]  slot;
  logic [31:0] expanded;
  logic        in_fire;
  logic        out_fire;
  logic        expanding;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign slot      = cnt[3:0];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign expanding = (state == EMIT) && (cnt >= 6'd16);

  // Modulo-16 slot arithmetic: t-2, t-7, t-15 (= t+1) and t-16 (= t) wrap naturally in 4 bits.
  always_comb begin
    expanded = sig1(wbuf[slot - 4'd2]) + wbuf[slot - 4'd7]
             + sig0(wbuf[slot + 4'd1]) + wbuf[slot];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (in_fire && cnt == 6'd15) state_nxt = EMIT;
      EMIT: if (out_fire && cnt == LAST_T) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == EMIT);
    out_last  = (state == EMIT) && (cnt == LAST_T);
    busy      = (state != LOAD) || (cnt != 6'd0);
    out_word  = expanding ? expanded : wbuf[slot];
  end

`ifdef SHA256_SCHED_ROUND_IDX_EN
  assign out_round = (state == EMIT) ? cnt : 6'd0;
`else
`endif

  // Expanded words overwrite the slot of W[t-16], which is no longer needed once W[t] is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 6'd0;
      for (int i = 0; i < 16; i++) wbuf[i] <= 32'd0;
    end else if (in_fire) begin
      wbuf[slot] <= in_word;
      cnt        <= (cnt == 6'd15) ? 6'd0 : cnt + 6'd1;
    end else if (out_fire) begin
      if (expanding) wbuf[slot] <= expanded;
      cnt <= (cnt == LAST_T) ? 6'd0 : cnt + 6'd1;
    end
  end

endmodule
